// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared state encoding, default width and overflow helper
//                for the bit-serial subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_DEFAULT_NUM_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Signed overflow of a subtraction: operands differ in sign and the
    // result sign differs from the minuend.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/subtractor_1bit.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_1bit
//  Description : Combinational one-bit full subtractor (a - b - borrow_in).
//  Revision    : 1.0  initial release
// ============================================================================
module subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial, LSB-first subtractor computing a - b - borrow_in
//                over NUM_BITS cycles with borrow and signed-overflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int NUM_BITS = c_DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);

    localparam int                 c_CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_BITS - 1);

    state_e              r_state_q,      w_state_d;
    logic [NUM_BITS-1:0] r_a_q,          w_a_d;
    logic [NUM_BITS-1:0] r_b_q,          w_b_d;
    logic [NUM_BITS-1:0] r_res_q,        w_res_d;
    logic                r_bw_q,         w_bw_d;
    logic [c_CNT_W-1:0]  r_cnt_q,        w_cnt_d;
    logic                r_a_msb_q,      w_a_msb_d;
    logic                r_b_msb_q,      w_b_msb_d;
    logic [NUM_BITS-1:0] r_diff_q,       w_diff_d;
    logic                r_borrow_out_q, w_borrow_out_d;
    logic                r_overflow_q,   w_overflow_d;

    logic                w_bit_diff;
    logic                w_bit_borrow;

    subtractor_1bit u_bit (
        .a          (r_a_q[0]),
        .b          (r_b_q[0]),
        .borrow_in  (r_bw_q),
        .diff       (w_bit_diff),
        .borrow_out (w_bit_borrow)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_a_d          = r_a_q;
        w_b_d          = r_b_q;
        w_res_d        = r_res_q;
        w_bw_d         = r_bw_q;
        w_cnt_d        = r_cnt_q;
        w_a_msb_d      = r_a_msb_q;
        w_b_msb_d      = r_b_msb_q;
        w_diff_d       = r_diff_q;
        w_borrow_out_d = r_borrow_out_q;
        w_overflow_d   = r_overflow_q;

        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_bw_d    = borrow_in;
                    w_cnt_d   = '0;
                    w_res_d   = '0;
                    // Operand MSBs are shifted away, so keep them for overflow.
                    w_a_msb_d = a[NUM_BITS-1];
                    w_b_msb_d = b[NUM_BITS-1];
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                w_res_d = {w_bit_diff, r_res_q[NUM_BITS-1:1]};
                w_a_d   = r_a_q >> 1;
                w_b_d   = r_b_q >> 1;
                w_bw_d  = w_bit_borrow;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST) begin
                    w_diff_d       = w_res_d;
                    w_borrow_out_d = w_bit_borrow;
                    w_overflow_d   = sub_overflow(r_a_msb_q, r_b_msb_q, w_bit_diff);
                    w_state_d      = DONE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_res_q        <= '0;
            r_bw_q         <= 1'b0;
            r_cnt_q        <= '0;
            r_a_msb_q      <= 1'b0;
            r_b_msb_q      <= 1'b0;
            r_diff_q       <= '0;
            r_borrow_out_q <= 1'b0;
            r_overflow_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_a_q          <= w_a_d;
            r_b_q          <= w_b_d;
            r_res_q        <= w_res_d;
            r_bw_q         <= w_bw_d;
            r_cnt_q        <= w_cnt_d;
            r_a_msb_q      <= w_a_msb_d;
            r_b_msb_q      <= w_b_msb_d;
            r_diff_q       <= w_diff_d;
            r_borrow_out_q <= w_borrow_out_d;
            r_overflow_q   <= w_overflow_d;
        end
    end

    assign busy       = (r_state_q == SHIFT);
    assign done       = (r_state_q == DONE);
    assign diff       = r_diff_q;
    assign borrow_out = r_borrow_out_q;
    assign overflow   = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor (8-bit
//                and 2-bit instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bo8, ov8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bo2, ov2;
    logic [1:0] a2, b2, diff2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.NUM_BITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
    );

    serial_subtractor #(.NUM_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .borrow_in(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2), .overflow(ov2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start an 8-bit operation, scramble inputs after capture, check latency and result.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ediff, input logic ebo, input logic eov,
                        input string tag);
        int edges;
        bit seen;
        @(negedge clk);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(posedge clk);
        edges = 1;
        seen  = 0;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ia; b8 = ib ^ 8'h5A; bin8 = ~ibin;
        chk({tag, " busy"}, 32'(busy8), 32'd1);
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done8) seen = 1;
        end
        chk({tag, " done_edges"}, 32'(edges), 32'd9);
        chk({tag, " diff"}, 32'(diff8), 32'(ediff));
        chk({tag, " borrow_out"}, 32'(bo8), 32'(ebo));
        chk({tag, " overflow"}, 32'(ov8), 32'(eov));
        @(negedge clk);
        chk({tag, " done_width"}, 32'(done8), 32'd0);
        chk({tag, " diff_hold"}, 32'(diff8), 32'(ediff));
    endtask

    task automatic run2(input logic [1:0] ia, input logic [1:0] ib, input logic ibin,
                        input logic [1:0] ediff, input logic ebo, input logic eov);
        int edges;
        bit seen;
        @(negedge clk);
        a2 = ia; b2 = ib; bin2 = ibin; start2 = 1'b1;
        @(posedge clk);
        edges = 1;
        seen  = 0;
        @(negedge clk);
        start2 = 1'b0; a2 = ~ia; b2 = ~ib; bin2 = ~ibin;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done2) seen = 1;
        end
        chk($sformatf("w2 %0d-%0d-%0d edges", ia, ib, ibin), 32'(edges), 32'd3);
        chk($sformatf("w2 %0d-%0d-%0d diff", ia, ib, ibin), 32'(diff2), 32'(ediff));
        chk($sformatf("w2 %0d-%0d-%0d borrow", ia, ib, ibin), 32'(bo2), 32'(ebo));
        chk($sformatf("w2 %0d-%0d-%0d ovf", ia, ib, ibin), 32'(ov2), 32'(eov));
    endtask

    initial begin
        int done_cnt;
        logic [7:0] seen_diff;

        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; bin8 = 1'b0;
        start2 = 1'b0; a2 = 2'h0; b2 = 2'h0; bin2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset diff", 32'(diff8), 32'd0);
        chk("reset borrow_out", 32'(bo8), 32'd0);
        chk("reset overflow", 32'(ov8), 32'd0);
        rst = 1'b0;

        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "5-3");
        run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "3-5");
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80-01");
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "0-0-1");
        run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7F-FF");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF-FF-1");

        // start re-asserted in the third SHIFT cycle must be ignored
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        done_cnt  = 0;
        seen_diff = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                done_cnt++;
                seen_diff = diff8;
            end
        end
        chk("ignore_start done_count", 32'(done_cnt), 32'd1);
        chk("ignore_start diff", 32'(seen_diff), 32'h02);
        chk("ignore_start borrow_out", 32'(bo8), 32'd0);

        // reset in the fourth SHIFT cycle abandons the operation
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", 32'(busy8), 32'd0);
        chk("midreset done", 32'(done8), 32'd0);
        chk("midreset diff", 32'(diff8), 32'd0);
        chk("midreset borrow_out", 32'(bo8), 32'd0);
        chk("midreset overflow", 32'(ov8), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) done_cnt++;
        end
        chk("midreset no_done", 32'(done_cnt), 32'd0);
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "post_reset");

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        chk("rst_vs_start busy", 32'(busy8), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_vs_start still_idle", 32'(busy8), 32'd0);
        chk("rst_vs_start diff", 32'(diff8), 32'd0);

        // exhaustive 2-bit sweep against an arithmetic model
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int sa, sb, sr, ur;
                    sa = (ia >= 2) ? ia - 4 : ia;
                    sb = (ib >= 2) ? ib - 4 : ib;
                    sr = sa - sb - ic;
                    ur = ia - ib - ic;
                    run2(2'(ia), 2'(ib), 1'(ic), 2'(ur & 3), (ur < 0),
                         (sr < -2) || (sr > 1));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, operand width (legal 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-005 SHALL have port a, input, NUM_BITS, minuend; captured on accepted start.
REQ-006 SHALL have port b, input, NUM_BITS, subtrahend; captured on accepted start.
REQ-007 SHALL have port borrow_in, input, 1, initial borrow; captured on accepted start.
REQ-008 SHALL have port busy, output, 1, high while in SHIFT.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port diff, output, NUM_BITS, a - b - borrow_in, modulo 2^NUM_BITS.
REQ-011 SHALL have port borrow_out, output, 1, final borrow (unsigned a < b + borrow_in).
REQ-012 SHALL have port overflow, output, 1, two's-complement overflow of the subtraction.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1 SHALL load a and b into operand shift registers, set the borrow flop to borrow_in, clear the bit counter, and go to SHIFT.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 Each SHIFT cycle SHALL process one bit LSB-first:
- d = a0 ^ b0 ^ bw
- bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw)
- shift d into the result register from the MSB end
- shift both operand registers right by one
- increment the counter
REQ-017 SHIFT SHALL move to DONE after exactly NUM_BITS processed bits.
REQ-018 DONE SHALL:
- assert done for one cycle
- update diff, borrow_out and overflow on the transition into DONE
- return to IDLE unconditionally
REQ-019 Latency: start accepted at edge N0 -> done high in the cycle after edge N0+NUM_BITS.
- For NUM_BITS=8: start sampled at edge 0, done visible in the cycle following edge 8.
REQ-020 overflow SHALL equal (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using captured operands.
REQ-021 diff, borrow_out and overflow SHALL hold their values until the next completion or reset.
REQ-022 start SHALL be ignored in SHIFT and DONE, with no effect on operands or counter.
REQ-023 Input changes on a, b and borrow_in after capture SHALL NOT affect the result.
REQ-024 The counter SHALL be $clog2(NUM_BITS+1) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE and clear all of the following to 0:
- busy, done, diff, borrow_out, overflow
- counter, borrow flop, shift registers
REQ-026 Reset asserted mid-SHIFT SHALL abandon the operation with no done pulse.
REQ-027 Reset SHALL take priority over a simultaneous start.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default-width constant.
REQ-029 The per-bit logic SHALL be one combinational sub-module, subtractor_1bit, with ports a, b, borrow_in, diff, borrow_out.
REQ-030 Everything else, including the FSM, counter and shift registers, SHALL reside in serial_subtractor.

Verification
REQ-031 a=0x05, b=0x03, borrow_in=0 -> diff=0x02, borrow_out=0, overflow=0; done exactly 9 edges after start.
REQ-032 a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-033 Overflow and borrow-chain cases:
- a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1
REQ-034 start pulsed at cycle 3 of SHIFT with different operands -> ignored; original result returned; exactly one done.
REQ-035 rst asserted at cycle 4 of SHIFT -> next cycle IDLE, all outputs 0, no done pulse; a fresh start then completes correctly.
REQ-036 NUM_BITS=2, all 32 (a, b, borrow_in) combinations -> diff and borrow_out match a - b - borrow_in modulo 4 in every case.
